// File: rtl/compt_pkg.sv
// Shared definitions for the timer arbiter: FSM encoding and default sizes.
package compt_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/compt_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping around to bit 0.
module compt_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            valid,
  output logic [2:0]      w
);

  int idx;

  // Scan from the farthest position back toward ptr so the closest hit wins.
  always_comb begin
    valid = |req;
    w     = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (|(req & (NREQ'(1) << idx))) begin
        w = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/compt_timer_arbiter.sv
// Round-robin arbiter that lends one shared interval counter to NREQ
// requesters, one timed window at a time, and pulses done at window end.
module compt_timer_arbiter
  import compt_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [2:0]      owner,
  output logic [W-1:0]    cnt
);

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      ptr;
  logic [W-1:0]    len_q;
  logic [W-1:0]    len_sel;
  logic [W-1:0]    last_cnt;
  logic [2:0]      pick_w;
  logic            pick_valid;
  logic [NREQ-1:0] owner_hot;
  logic            owner_req;

  compt_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .w     (pick_w)
  );

  // A length of 0 wraps to all-ones here, giving a full 2^W-cycle window.
  assign last_cnt  = len_q - W'(1);
  assign owner_hot = NREQ'(1) << owner;
  assign owner_req = |(req & owner_hot);

  // Select the window length of the requester the picker would grant.
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_w == 3'(i)) begin
        len_sel = len[i*W +: W];
      end
    end
  end

  // Next-state decision: grant, abort, window end, and the DONE turnaround.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_valid) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!owner_req) begin
          state_nxt = ST_IDLE;
        end else if (cnt == last_cnt) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, window counter, owner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pick_valid) begin
            owner <= pick_w;
            ptr   <= (pick_w == 3'(NREQ - 1)) ? 3'd0 : pick_w + 3'd1;
          end
        end
        ST_RUN:  cnt <= (state_nxt == ST_RUN) ? cnt + W'(1) : '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Window length is captured at grant time; later len changes are ignored.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && pick_valid) begin
      len_q <= len_sel;
    end
  end

  // Outputs decode registered state only, so nothing ripples from req or len.
  always_comb begin
    busy = (state == ST_RUN);
    gnt  = (state == ST_RUN)  ? owner_hot : '0;
    done = (state == ST_DONE) ? owner_hot : '0;
  end

endmodule

// File: tb/tb_compt_timer_arbiter.sv
// Scoreboard bench for compt_timer_arbiter: a round-robin window model pushes
// expected grants, a monitor checks every window cycle by cycle.
module tb_compt_timer_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  typedef struct {
    int idx;
    int len;
    int abort_at;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] len;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [2:0]        owner;
  logic [W-1:0]      cnt;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   mptr   = 0;
  int   lens[NREQ];
  exp_t sb[$];

  compt_timer_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .owner (owner),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic apply_lens();
    for (int i = 0; i < NREQ; i++) len[i*W +: W] = W'(lens[i]);
  endtask

  // Reference: windows are served in rotating order starting at the pointer,
  // skipping requesters not in the mask; pointer moves past each winner.
  task automatic run_phase(input logic [NREQ-1:0] mask, input int nwin,
                           input bit hold, input int abort_at);
    int   idx;
    int   finished;
    int   cyc;
    int   bound;
    exp_t e;
    idx = mptr;
    for (int n = 0; n < nwin; n++) begin
      while (mask[idx] == 1'b0) idx = (idx + 1) % NREQ;
      e.idx      = idx;
      e.len      = (lens[idx] == 0) ? 256 : lens[idx];
      e.abort_at = abort_at;
      sb.push_back(e);
      idx = (idx + 1) % NREQ;
    end
    mptr = idx;

    apply_lens();
    req      = mask;
    finished = 0;
    cyc      = 0;
    bound    = nwin * 300 + 50;
    while (finished < nwin) begin
      @(negedge clk);
      cyc++;
      if (cyc > bound) begin
        chk("phase_timeout", finished, nwin);
        break;
      end
      if (abort_at >= 0 && gnt != 0 && int'(cnt) == abort_at) begin
        req = '0;
        finished++;
      end else if (done != 0) begin
        finished++;
        apply_lens();
        if (hold) begin
          if (finished == nwin) req = '0;
        end else begin
          req = req & ~done;
        end
      end else if (abort_at < 0 && gnt != 0 && cnt == 8'd1) begin
        len = (NREQ*W)'($urandom);
      end
    end
    req = '0;
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  exp_t mon_e;
  int   mon_hot;
  int   mon_last;

  // Monitor: pops one expected window per grant and checks it cycle by cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en || rst) continue;
      if (gnt == 0) begin
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_cnt", int'(cnt), 0);
      end else if (sb.size() == 0) begin
        chk("unexpected_gnt", int'(gnt), 0);
      end else begin
        mon_e    = sb.pop_front();
        mon_hot  = 1 << mon_e.idx;
        mon_last = (mon_e.abort_at >= 0) ? mon_e.abort_at : mon_e.len - 1;
        for (int k = 0; k <= mon_last; k++) begin
          if (k > 0) @(negedge clk);
          chk("win_gnt", int'(gnt), mon_hot);
          chk("win_cnt", int'(cnt), k);
          chk("win_owner", int'(owner), mon_e.idx);
          chk("win_busy", int'(busy), 1);
          chk("win_done", int'(done), 0);
        end
        @(negedge clk);
        chk("end_gnt", int'(gnt), 0);
        chk("end_cnt", int'(cnt), 0);
        chk("end_busy", int'(busy), 0);
        chk("end_done", int'(done), (mon_e.abort_at >= 0) ? 0 : mon_hot);
        if (mon_e.abort_at < 0) begin
          @(negedge clk);
          chk("gap_gnt", int'(gnt), 0);
          chk("gap_done", int'(done), 0);
        end
      end
    end
  end

  // Stimulus: directed scenarios, random phases, then a mid-window reset.
  initial begin
    logic [NREQ-1:0] mask;
    int              nwin;
    bit              hold;
    int              wait_cyc;

    rst = 1'b1;
    req = '0;
    len = '0;
    for (int i = 0; i < NREQ; i++) lens[i] = 1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_cnt", int'(cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < NREQ; i++) lens[i] = 2;
    run_phase(4'b1011, 6, 1'b1, -1);

    lens[0] = 3;
    run_phase(4'b0001, 1, 1'b0, -1);

    lens[2] = 0;
    run_phase(4'b0100, 1, 1'b0, -1);

    lens[1] = 1;
    run_phase(4'b0010, 1, 1'b0, -1);

    lens[0] = 10;
    run_phase(4'b0001, 1, 1'b0, 4);

    for (int i = 0; i < NREQ; i++) lens[i] = i + 2;
    run_phase(4'b1111, 4, 1'b0, -1);

    for (int p = 0; p < 15; p++) begin
      mask = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) lens[i] = $urandom_range(1, 7);
      hold = 1'($urandom_range(0, 1));
      nwin = hold ? $urandom_range(1, 6) : $countones(mask);
      run_phase(mask, nwin, hold, -1);
    end

    mon_en = 1'b0;
    lens[0] = 20;
    apply_lens();
    req = 4'b0001;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (!(gnt[0] && cnt == 8'd5) && wait_cyc < 50);
    chk("rstmid_reached", int'(cnt), 5);
    rst = 1'b1;
    #1;
    chk("rstmid_gnt", int'(gnt), 0);
    chk("rstmid_done", int'(done), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_cnt", int'(cnt), 0);
    chk("rstmid_owner", int'(owner), 0);
    req = 4'b1111;
    repeat (2) @(negedge clk);
    chk("rstmid_hold_gnt", int'(gnt), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_gnt", int'(gnt), 1);
    chk("after_rst_owner", int'(owner), 0);
    req = '0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/compt_timer_arbiter.md
# compt_timer_arbiter

Shares one 8-bit interval counter among `NREQ` requesters. Each requester asks for an exclusive timed window of `len` cycles. The block arbitrates round-robin, grants one requester, counts the window and pulses `done` at the end. It sits beside the 8-bit counter datapath and replaces ad-hoc per-requester counters with one scheduled resource.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8
- `W`, 8: counter and length width

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `req`  in  NREQ  per-requester request level; held high until `done` is seen
- `len`  in  NREQ*W  packed window lengths; requester i uses `len[i*W +: W]`; 0 means 2^W cycles
- `gnt`  out  NREQ  one-hot grant, high for the whole window
- `done`  out  NREQ  one-cycle pulse to the owner at normal window end
- `busy`  out  1  high while in RUN
- `owner`  out  3  index of the current or last granted requester
- `cnt`  out  W  current window count, 0 outside RUN

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE; all outputs reset to 0; the round-robin pointer `ptr` resets to 0.
- IDLE: if `req != 0`, pick the first set bit scanning from `ptr` upward with wrap. At the next edge:
  - state becomes RUN, `gnt[w]`=1 and `owner`=w
  - `len_q` latches `len[w]`; `cnt` becomes 0
  - `ptr` becomes (w+1) mod NREQ
- RUN, each edge:
  - If `req[w]`=0 (abort): go to IDLE, `gnt`=0, `cnt`=0, no `done` pulse.
  - Else if `cnt == len_q-1` (W-bit wrap, so `len_q`=0 compares against 2^W-1): go to DONE, `gnt`=0, `done[w]`=1, `cnt`=0.
  - Else `cnt` increments by 1.
- DONE: `done` is high for this cycle only. The next edge returns to IDLE unconditionally.
- `len` changes during RUN are ignored; only `len_q` is used.
- Requests arriving during RUN or DONE wait. Request order inside IDLE does not matter; only `ptr` decides priority.
- A requester that keeps `req` high after `done` is treated as a new request and competes at `ptr` priority, so it cannot starve the others.
- `rst` during any state: immediate return to reset values. No `done` pulse is emitted.

## Timing
- Request to grant: 1 cycle from the IDLE cycle in which `req` is sampled high.
- Window: `gnt` is high for exactly L cycles (L = `len_q`, or 2^W if 0). `cnt` runs 0..L-1 during those cycles.
- `done` is asserted in the cycle right after the last `gnt` cycle, for 1 cycle.
- Turnaround from end of window to next grant is at least 2 cycles (DONE, then IDLE).
- `gnt` and `done` are never high together. At most one `gnt` bit is set at a time.
- All outputs are registered; no combinational path from `req` or `len` to any output.

## Structure
- Package `compt_pkg`: state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default `NREQ`/`W` constants.
- Sub-module `compt_rr_pick`: combinational round-robin picker. Inputs `req` and `ptr`; outputs `valid` and index `w`.
- All state, `cnt`, `len_q` and `ptr` live in the top module.

## Test plan
- Single request: `req`=0001, `len0`=3 → `gnt`=0001 for 3 cycles with `cnt` 0,1,2; then `done`=0001 for 1 cycle; `busy` drops with `gnt`.
- Contention: `req`=1011 held, all lengths 2 → grant order 0,1,3,0,1,3. Each `done` pulses once per window, with 2 idle cycles between windows.
- Length zero: `len2`=0, `req`=0100 → `gnt[2]` high for 256 cycles, `cnt` reaches 255, then `done[2]`.
- Length one: `len1`=1 → `gnt[1]` for 1 cycle with `cnt`=0, `done[1]` the next cycle.
- Abort: `len0`=10; drop `req[0]` when `cnt`=4 → `gnt`=0 and `cnt`=0 the next cycle, no `done`, `ptr`=1.
- Reset mid-run: assert `rst` at `cnt`=5 → `gnt`, `done`, `busy`, `cnt`, `owner` all 0 immediately. After release with `req`=1111, requester 0 is granted first.
